universal_shift_register: RTL and testbench

Parametrised N-bit register with hold, parallel load, shift, rotate and clear modes, plus a built-in serialiser that shifts the full word out LSB-first on a single start pulse. It generalises the team's plain load register. It is the common storage/serial-conversion element for datapaths and simple serial links. Parallel output is always the registered state.

---
 rtl/universal_shift_register.sv | 92 +++++++++
 tb/tb_universal_shift_register.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_register.sv
// N-bit hold/load/shift/rotate/clear register with an LSB-first serialiser started by a single pulse.
// Rotate modes are compiled only when UNIV_SHIFT_REG_ROTATE_EN is defined; otherwise 100/101 hold.
module universal_shift_register #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [2:0]   mode,
    input  logic [N-1:0] I,
    input  logic         sin_l,
    input  logic         sin_r,
    input  logic         start,
    output logic [N-1:0] Q,
    output logic         sout,
    output logic         busy,
    output logic         done
);
    localparam int CW = $clog2(N + 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_LOAD  = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_SHR   = 3'b011;
    localparam logic [2:0] MODE_ROTL  = 3'b100;
    localparam logic [2:0] MODE_ROTR  = 3'b101;
    localparam logic [2:0] MODE_CLEAR = 3'b110;

    localparam logic [CW-1:0] LAST_SHIFT = CW'(N - 1);

    logic [N-1:0]  q_q, q_d;
    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    always_comb begin
        q_d     = q_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (state_q == S_SHIFT) begin
            // Serialising: mode/start/I are ignored until the N-th shift completes.
            q_d   = {sin_r, q_q[N-1:1]};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST_SHIFT) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
        end else if (start) begin
            state_d = S_SHIFT;
            cnt_d   = '0;
            if (mode == MODE_LOAD) begin
                q_d = I;
            end
        end else begin
            case (mode)
                MODE_HOLD:  q_d = q_q;
                MODE_LOAD:  q_d = I;
                MODE_SHL:   q_d = {q_q[N-2:0], sin_l};
                MODE_SHR:   q_d = {sin_r, q_q[N-1:1]};
`ifdef UNIV_SHIFT_REG_ROTATE_EN
                MODE_ROTL:  q_d = {q_q[N-2:0], q_q[N-1]};
                MODE_ROTR:  q_d = {q_q[0], q_q[N-1:1]};
`endif
                MODE_CLEAR: q_d = '0;
                default:    q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q     <= '0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            q_q     <= q_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign Q    = q_q;
    assign sout = q_q[0];
    assign busy = (state_q == S_SHIFT);
    assign done = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Bench for universal_shift_register: N=2, 8 and 16 instances run in lockstep against a behavioural model.
module tb_universal_shift_register;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  mode;
    logic        sin_l, sin_r, start;
    logic [1:0]  I2, Q2;
    logic [7:0]  I8, Q8;
    logic [15:0] I16, Q16;
    logic        sout2, sout8, sout16;
    logic        busy2, busy8, busy16;
    logic        done2, done8, done16;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        int q;
        int rem;
        bit done;
    } mst_t;

    mst_t m2, m8, m16;

    always #5 clk = ~clk;

    universal_shift_register #(.N(2)) u_n2 (
        .clk(clk), .reset_n(reset_n), .mode(mode), .I(I2), .sin_l(sin_l), .sin_r(sin_r),
        .start(start), .Q(Q2), .sout(sout2), .busy(busy2), .done(done2));
    universal_shift_register #(.N(8)) u_n8 (
        .clk(clk), .reset_n(reset_n), .mode(mode), .I(I8), .sin_l(sin_l), .sin_r(sin_r),
        .start(start), .Q(Q8), .sout(sout8), .busy(busy8), .done(done8));
    universal_shift_register #(.N(16)) u_n16 (
        .clk(clk), .reset_n(reset_n), .mode(mode), .I(I16), .sin_l(sin_l), .sin_r(sin_r),
        .start(start), .Q(Q16), .sout(sout16), .busy(busy16), .done(done16));

    // Reference: the word as an integer, plus the number of serial shifts still owed.
    function automatic mst_t mnext(mst_t s, int w, logic [2:0] md, int iv,
                                   logic sl, logic sr, logic st);
        mst_t n;
        int   mask;
        mask   = (1 << w) - 1;
        n      = s;
        n.done = 1'b0;
        if (s.rem > 0) begin
            n.q   = (s.q >> 1) | (int'(sr) << (w - 1));
            n.rem = s.rem - 1;
            n.done = (n.rem == 0);
        end else if (st) begin
            n.rem = w;
            if (md == 3'd1) n.q = iv & mask;
        end else begin
            case (md)
                3'd1: n.q = iv & mask;
                3'd2: n.q = ((s.q << 1) | int'(sl)) & mask;
                3'd3: n.q = (s.q >> 1) | (int'(sr) << (w - 1));
`ifdef UNIV_SHIFT_REG_ROTATE_EN
                3'd4: n.q = ((s.q << 1) | (s.q >> (w - 1))) & mask;
                3'd5: n.q = (s.q >> 1) | ((s.q & 1) << (w - 1));
`endif
                3'd6: n.q = 0;
                default: n.q = s.q;
            endcase
        end
        return n;
    endfunction

    function automatic mst_t mreset();
        mst_t r;
        r.q = 0; r.rem = 0; r.done = 1'b0;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_one(input string tg, input mst_t m, input logic [15:0] q,
                             input logic b, input logic d, input logic so);
        chk({tg, ".Q"},    q,           16'(m.q));
        chk({tg, ".busy"}, {15'b0, b},  16'(m.rem > 0));
        chk({tg, ".done"}, {15'b0, d},  16'(m.done));
        chk({tg, ".sout"}, {15'b0, so}, 16'(m.q & 1));
    endtask

    task automatic check_all();
        check_one("n2",  m2,  {14'b0, Q2}, busy2,  done2,  sout2);
        check_one("n8",  m8,  {8'b0, Q8},  busy8,  done8,  sout8);
        check_one("n16", m16, Q16,         busy16, done16, sout16);
    endtask

    task automatic step();
        m2  = mnext(m2,  2,  mode, int'(I2),  sin_l, sin_r, start);
        m8  = mnext(m8,  8,  mode, int'(I8),  sin_l, sin_r, start);
        m16 = mnext(m16, 16, mode, int'(I16), sin_l, sin_r, start);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && (busy2 || busy8 || busy16); i++) step();
        chk("idle_wait", {13'b0, busy2, busy8, busy16}, 16'h0);
    endtask

    initial begin
        logic [7:0]  exp8;
        logic [15:0] s16;
        logic [1:0]  s2;
        int          t_done[$];
        int          cyc, b2, b8, b16, d2, d8, d16;

        reset_n = 1'b0; mode = 3'd0; sin_l = 1'b0; sin_r = 1'b0; start = 1'b0;
        I2 = '0; I8 = '0; I16 = '0;
        m2 = mreset(); m8 = mreset(); m16 = mreset();
        #12;
        check_all();
        reset_n = 1'b1;

        // Directed mode walk on the 8-bit instance.
        mode = 3'd1; I8 = 8'h81; step(); chk("load", {8'b0, Q8}, 16'h81);
        mode = 3'd2; sin_l = 1'b1; step(); chk("shl", {8'b0, Q8}, 16'h03);
        mode = 3'd3; sin_r = 1'b0; step(); chk("shr", {8'b0, Q8}, 16'h01);
        mode = 3'd5; step();
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        chk("rotr", {8'b0, Q8}, 16'h80);
`else
        chk("rotr", {8'b0, Q8}, 16'h01);
`endif
        mode = 3'd6; step(); chk("clear", {8'b0, Q8}, 16'h00);
        mode = 3'd1; I8 = 8'h5A; step();
        mode = 3'd7; I8 = 8'hFF; step(); chk("mode111", {8'b0, Q8}, 16'h5A);

        // Asynchronous reset in the middle of a serialise, no clock edge.
        mode = 3'd1; I8 = 8'hA5; step();
        mode = 3'd0; start = 1'b1; step(); start = 1'b0;
        chk("pre_rst.busy", {15'b0, busy8}, 16'h1);
        chk("pre_rst.Q", {8'b0, Q8}, 16'hA5);
        #3 reset_n = 1'b0;
        #1;
        chk("async_rst.Q", {8'b0, Q8}, 16'h0);
        chk("async_rst.busy", {15'b0, busy8}, 16'h0);
        chk("async_rst.done", {15'b0, done8}, 16'h0);
        m2 = mreset(); m8 = mreset(); m16 = mreset();
        check_all();
        #1 reset_n = 1'b1;

        // Load-and-send 0xB4.
        mode = 3'd1; I8 = 8'hB4; I2 = 2'b10; I16 = 16'hC3A5; sin_r = 1'b0; start = 1'b1;
        step();
        start = 1'b0; mode = 3'd0;
        exp8 = 8'hB4;
        for (int k = 0; k < 8; k++) begin
            chk("las.sout", {15'b0, sout8}, {15'b0, exp8[k]});
            chk("las.busy", {15'b0, busy8}, 16'h1);
            step();
        end
        chk("las.end_busy", {15'b0, busy8}, 16'h0);
        chk("las.done", {15'b0, done8}, 16'h1);
        chk("las.finalQ", {8'b0, Q8}, 16'h0);
        step();
        chk("las.done_fall", {15'b0, done8}, 16'h0);

        // Mode/start/I activity during SHIFT must be ignored.
        wait_idle();
        mode = 3'd1; I8 = 8'h3C; start = 1'b1; step();
        exp8 = 8'h3C;
        for (int k = 0; k < 8; k++) begin
            mode = 3'd1; I8 = 8'hFF; start = k[0];
            chk("ign.sout", {15'b0, sout8}, {15'b0, exp8[k]});
            n_assert++;
            assert (Q8 !== 8'hFF) else begin
                n_fail++;
                $error("FAIL ign.noload: observed %h expected not ff", Q8);
            end
            step();
        end
        chk("ign.done", {15'b0, done8}, 16'h1);
        start = 1'b0; mode = 3'd0;

        // Back-to-back: start in the done cycle.
        wait_idle();
        mode = 3'd1; I8 = 8'h96; start = 1'b1; step();
        start = 1'b0; mode = 3'd0; cyc = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            cyc++;
            if (done8) begin
                t_done.push_back(cyc);
                start = (t_done.size() == 1);
            end else begin
                start = 1'b0;
            end
        end
        chk("b2b.count", 16'(t_done.size()), 16'd2);
        chk("b2b.first", 16'(t_done.size() > 0 ? t_done[0] : -1), 16'd8);
        chk("b2b.gap", 16'(t_done.size() > 1 ? t_done[1] - t_done[0] : -1), 16'd9);
        start = 1'b0;

        // Width sweep: occupancy and LSB-first order for N=2, 8, 16.
        wait_idle();
        mode = 3'd1; I2 = 2'b01; I8 = 8'hE7; I16 = 16'hA5C3; sin_r = 1'b1; start = 1'b1;
        step();
        start = 1'b0; mode = 3'd0;
        b2 = 0; b8 = 0; b16 = 0; d2 = -1; d8 = -1; d16 = -1; s2 = '0; s16 = '0;
        for (int c = 0; c < 20; c++) begin
            if (busy2)  b2++;
            if (busy8)  b8++;
            if (busy16) b16++;
            if (done2  && d2  < 0) d2  = c;
            if (done8  && d8  < 0) d8  = c;
            if (done16 && d16 < 0) d16 = c;
            if (c < 2)  s2[c]  = sout2;
            if (c < 16) s16[c] = sout16;
            step();
        end
        chk("sweep.busy2", 16'(b2), 16'd2);
        chk("sweep.busy8", 16'(b8), 16'd8);
        chk("sweep.busy16", 16'(b16), 16'd16);
        chk("sweep.done2", 16'(d2), 16'd2);
        chk("sweep.done8", 16'(d8), 16'd8);
        chk("sweep.done16", 16'(d16), 16'd16);
        chk("sweep.order2", {14'b0, s2}, 16'h1);
        chk("sweep.order16", s16, 16'hA5C3);
        chk("sweep.fill16", Q16, 16'hFFFF);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            mode  = 3'($urandom_range(0, 7));
            start = ($urandom_range(0, 3) == 0);
            sin_l = 1'($urandom);
            sin_r = 1'($urandom);
            I2    = 2'($urandom);
            I8    = 8'($urandom);
            I16   = 16'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
